// File: rtl/lsu_sram_slave.sv
// lsu_sram_slave: responder end of the LSU load/store bus, backed by a
// word-addressed SRAM. Read and write channels run independently.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   araddr_i/arvalid_i/arready_o read address channel
//   rdata_o/rvalid_o/rready_i    read data channel
//   awaddr_i/awvalid_i/awready_o write address channel
//   wdata_i/wstrb_i/wvalid_i/wready_o write data channel
//   bresp_o/bvalid_o/bready_i    write response (2'b00 OK, 2'b10 out of range)
module lsu_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned STRB_WIDTH  = 4,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_WIDTH-1:0] wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [1:0]            bresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Address decode: offset from base, range check on the full byte offset.
    logic [ADDR_WIDTH-1:0] ar_off, aw_off;
    logic                  ar_ok, aw_ok;
    logic [IDX_W-1:0]      ar_idx, aw_idx;

    always_comb begin
        ar_off = araddr_i - BASE_ADDR;
        aw_off = awaddr_i - BASE_ADDR;
        ar_ok  = (araddr_i >= BASE_ADDR) && ({1'b0, ar_off} < SPAN);
        aw_ok  = (awaddr_i >= BASE_ADDR) && ({1'b0, aw_off} < SPAN);
        ar_idx = ar_off[IDX_W+1:2];
        aw_idx = aw_off[IDX_W+1:2];
    end

    // ---------------- read channel ----------------
    rd_state_e             rd_state_q;
    logic [3:0]            rd_cnt_q;
    logic [IDX_W-1:0]      rd_idx_q;
    logic                  rd_ok_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    assign arready_o = (rd_state_q == RD_IDLE);
    assign rdata_o   = rdata_q;
    assign rvalid_o  = rvalid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_state_q <= RD_IDLE;
            rd_cnt_q   <= '0;
            rd_idx_q   <= '0;
            rd_ok_q    <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            case (rd_state_q)
                RD_IDLE: if (arvalid_i) begin
                    rd_idx_q   <= ar_idx;
                    rd_ok_q    <= ar_ok;
                    rd_cnt_q   <= 4'(RD_LATENCY - 1);
                    rd_state_q <= RD_WAIT;
                end
                RD_WAIT: if (rd_cnt_q == '0) begin
                    // Nonblocking sample gives old data on a same-edge write.
                    rdata_q    <= rd_ok_q ? mem[rd_idx_q] : '0;
                    rvalid_q   <= 1'b1;
                    rd_state_q <= RD_RESP;
                end else begin
                    rd_cnt_q <= rd_cnt_q - 4'd1;
                end
                RD_RESP: if (rready_i) begin
                    rvalid_q   <= 1'b0;
                    rd_state_q <= RD_IDLE;
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    // ---------------- write channel ----------------
    wr_state_e             wr_state_q;
    logic [IDX_W-1:0]      wr_idx_q;
    logic                  wr_ok_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic [1:0]            bresp_q;
    logic                  bvalid_q;

    assign awready_o = (wr_state_q == WR_IDLE) || (wr_state_q == WR_HAVE_W);
    assign wready_o  = (wr_state_q == WR_IDLE) || (wr_state_q == WR_HAVE_AW);
    assign bresp_o   = bresp_q;
    assign bvalid_o  = bvalid_q;

    logic                  aw_hs, w_hs, wr_done;
    logic                  c_ok, c_en;
    logic [IDX_W-1:0]      c_idx;
    logic [DATA_WIDTH-1:0] c_data;
    logic [STRB_WIDTH-1:0] c_strb;

    // Merge the latched half of the transaction with the half arriving now.
    always_comb begin
        aw_hs   = awvalid_i && awready_o;
        w_hs    = wvalid_i && wready_o;
        wr_done = ((wr_state_q == WR_IDLE)    && aw_hs && w_hs) ||
                  ((wr_state_q == WR_HAVE_AW) && w_hs) ||
                  ((wr_state_q == WR_HAVE_W)  && aw_hs);
        c_ok    = (wr_state_q == WR_HAVE_AW) ? wr_ok_q  : aw_ok;
        c_idx   = (wr_state_q == WR_HAVE_AW) ? wr_idx_q : aw_idx;
        c_data  = (wr_state_q == WR_HAVE_W)  ? wdata_q  : wdata_i;
        c_strb  = (wr_state_q == WR_HAVE_W)  ? wstrb_q  : wstrb_i;
        c_en    = wr_done && c_ok && !rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= WR_IDLE;
            wr_idx_q   <= '0;
            wr_ok_q    <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= 2'b00;
            bvalid_q   <= 1'b0;
        end else begin
            if (aw_hs) begin
                wr_idx_q <= aw_idx;
                wr_ok_q  <= aw_ok;
            end
            if (w_hs) begin
                wdata_q <= wdata_i;
                wstrb_q <= wstrb_i;
            end
            if (wr_done) begin
                bresp_q    <= c_ok ? 2'b00 : 2'b10;
                bvalid_q   <= 1'b1;
                wr_state_q <= WR_RESP;
            end else begin
                case (wr_state_q)
                    WR_IDLE: begin
                        if (aw_hs)     wr_state_q <= WR_HAVE_AW;
                        else if (w_hs) wr_state_q <= WR_HAVE_W;
                    end
                    WR_RESP: if (bready_i) begin
                        bvalid_q   <= 1'b0;
                        bresp_q    <= 2'b00;
                        wr_state_q <= WR_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage is never reset; commits are suppressed while rst_i is high.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (c_en && c_strb[i]) mem[c_idx][8*i +: 8] <= c_data[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_lsu_sram_slave.sv
module tb_lsu_sram_slave;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_sram_slave #(.RD_LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst),
        .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
        .rdata_o(rdata), .rvalid_o(rvalid), .rready_i(rready),
        .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
        .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rd;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // AW and W in the same cycle, then collect B.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_resp);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid", 32'(bvalid), 32'd1);
        chk("bresp", 32'(bresp), 32'(exp_resp));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_clr", 32'(bvalid), 32'd0);
    endtask

    // Read with latency check: rvalid low after edge N+LAT-1, high after N+LAT.
    task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
        araddr = a; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        repeat (LAT - 1) tick();
        chk("rvalid_early", 32'(rvalid), 32'd0);
        tick();
        chk("rvalid", 32'(rvalid), 32'd1);
        chk("rdata", rdata, exp);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("rvalid_clr", 32'(rvalid), 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        logic [31:0] held;
        int          n;

        vecs[0] = '{32'h8000_0010, 32'hA5A5_1234, 4'hF, 2'b00, 32'hA5A5_1234};
        vecs[1] = '{32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00, 32'h1122_3344};
        vecs[2] = '{32'h8000_0020, 32'h0000_FF00, 4'h2, 2'b00, 32'h1122_FF44};
        vecs[3] = '{32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h1122_FF44};
        vecs[4] = '{32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 2'b10, 32'h0000_0000};
        vecs[5] = '{32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 2'b00, 32'hCAFE_F00D};
        vecs[6] = '{32'h8000_1000, 32'h1234_5678, 4'hF, 2'b10, 32'h0000_0000};
        vecs[7] = '{32'h8000_0023, 32'hAB00_0000, 4'h8, 2'b00, 32'hAB22_FF44};
        vecs[8] = '{32'h7FFF_FFFC, 32'h0000_0001, 4'hF, 2'b10, 32'h0000_0000};

        rst = 1'b1; arvalid = 0; rready = 0; awvalid = 0; wvalid = 0; bready = 0;
        araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_awready", 32'(awready), 32'd1);
        chk("rst_wready", 32'(wready), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        chk("rst_rdata", rdata, 32'd0);

        foreach (vecs[i]) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
            do_read(vecs[i].addr, vecs[i].rd);
        end

        // W three cycles ahead of AW.
        wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("wfirst_wready", 32'(wready), 32'd0);
        chk("wfirst_awready", 32'(awready), 32'd1);
        tick(); tick();
        chk("wfirst_bvalid_wait", 32'(bvalid), 32'd0);
        awaddr = 32'h8000_0040; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("wfirst_bvalid", 32'(bvalid), 32'd1);
        chk("wfirst_bresp", 32'(bresp), 32'd0);
        bready = 1'b1; tick(); bready = 1'b0;
        do_read(32'h8000_0040, 32'h0BAD_F00D);

        // AW ahead of W.
        awaddr = 32'h8000_0044; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("awfirst_awready", 32'(awready), 32'd0);
        chk("awfirst_wready", 32'(wready), 32'd1);
        wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("awfirst_bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1; tick(); bready = 1'b0;
        do_read(32'h8000_0044, 32'h5555_AAAA);

        // Back-pressured read: response stays stable, no AR accepted.
        araddr = 32'h8000_0010; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        chk("stall_rvalid_up", 32'(rvalid), 32'd1);
        held = 32'hA5A5_1234;
        for (int k = 0; k < 5; k++) begin
            chk("stall_rvalid", 32'(rvalid), 32'd1);
            chk("stall_rdata", rdata, held);
            chk("stall_arready", 32'(arready), 32'd0);
            tick();
        end
        rready = 1'b1; tick(); rready = 1'b0;
        chk("stall_release_arready", 32'(arready), 32'd1);
        chk("stall_release_rvalid", 32'(rvalid), 32'd0);

        // Read sample and write commit on the same edge: old data returned.
        do_write(32'h8000_0080, 32'h1111_1111, 4'hF, 2'b00);
        araddr = 32'h8000_0080; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        repeat (LAT - 1) tick();
        awaddr = 32'h8000_0080; wdata = 32'h2222_2222; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("rf_rvalid", 32'(rvalid), 32'd1);
        chk("rf_rdata_old", rdata, 32'h1111_1111);
        chk("rf_bvalid", 32'(bvalid), 32'd1);
        rready = 1'b1; bready = 1'b1; tick(); rready = 1'b0; bready = 1'b0;
        do_read(32'h8000_0080, 32'h2222_2222);

        // Reset while a read is in RD_WAIT.
        araddr = 32'h8000_0010; arvalid = 1'b1;
        tick();
        arvalid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstrd_rvalid", 32'(rvalid), 32'd0);
        chk("rstrd_arready", 32'(arready), 32'd1);
        repeat (LAT + 1) tick();
        chk("rstrd_rvalid_later", 32'(rvalid), 32'd0);

        // Reset in WR_HAVE_AW, with the W beat offered on the reset edge.
        awaddr = 32'h8000_0010; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1; rst = 1'b1;
        tick();
        wvalid = 1'b0; rst = 1'b0;
        chk("rstwr_bvalid", 32'(bvalid), 32'd0);
        chk("rstwr_awready", 32'(awready), 32'd1);
        chk("rstwr_wready", 32'(wready), 32'd1);
        chk("rstwr_arready", 32'(arready), 32'd1);
        do_read(32'h8000_0010, 32'hA5A5_1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/lsu_sram_slave.md
LSU_SRAM_SLAVE -- requirements
Module: lsu_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data-word width.
REQ-003 SHALL have parameter STRB_WIDTH, default 4, write byte-strobe width (DATA_WIDTH/8).
REQ-004 SHALL have parameter DEPTH_WORDS, default 1024, number of storage words.
REQ-005 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-006 SHALL have parameter RD_LATENCY, default 1, cycles from AR handshake to rvalid; legal values 1..15.
REQ-007 SHALL have ports: clk_i in 1, the single clock; rst_i in 1, reset, synchronous, active-high.
REQ-008 SHALL have ports: araddr_i in ADDR_WIDTH; arvalid_i in 1; arready_o out 1; rdata_o out DATA_WIDTH; rvalid_o out 1; rready_i in 1.
REQ-009 SHALL have ports: awaddr_i in ADDR_WIDTH; awvalid_i in 1; awready_o out 1; wdata_i in DATA_WIDTH; wstrb_i in STRB_WIDTH; wvalid_i in 1; wready_o out 1.
REQ-010 SHALL have ports: bresp_o out 2, write response; bvalid_o out 1; bready_i in 1.

Function
REQ-011 SHALL act as the responder end of the LSU load/store bus; read and write channels operate independently and concurrently.
REQ-012 SHALL treat a handshake as valid&&ready sampled on a rising clk_i edge.
REQ-013 SHALL map address A to word index (A-BASE_ADDR)>>2; A[1:0] ignored; in range iff BASE_ADDR <= A < BASE_ADDR+4*DEPTH_WORDS.
REQ-014 Read FSM SHALL have states RD_IDLE, RD_WAIT, RD_RESP; arready_o = (state==RD_IDLE).
REQ-015 On AR handshake SHALL latch address, load latency counter with RD_LATENCY-1, go RD_WAIT; at counter 0 SHALL sample storage into rdata register and go RD_RESP.
REQ-016 rvalid_o SHALL be 1 exactly in RD_RESP; with AR handshake at edge N, rvalid_o rises after edge N+RD_LATENCY.
REQ-017 In RD_RESP, rdata_o and rvalid_o SHALL stay stable until rready_i; R handshake returns to RD_IDLE; no new AR accepted the same cycle.
REQ-018 Out-of-range read SHALL return rdata_o = 0 with normal timing.
REQ-019 Write FSM SHALL have states WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP.
REQ-020 awready_o SHALL be 1 in WR_IDLE and WR_HAVE_W; wready_o SHALL be 1 in WR_IDLE and WR_HAVE_AW; both 0 in WR_RESP.
REQ-021 AW alone from WR_IDLE -> WR_HAVE_AW; W alone -> WR_HAVE_W; both same cycle, or the missing one in WR_HAVE_*, -> WR_RESP.
REQ-022 On entering WR_RESP SHALL commit, at that same edge, byte lane i of wdata to the addressed word where wstrb[i]=1; other bytes unchanged.
REQ-023 bvalid_o SHALL be 1 exactly in WR_RESP (one cycle after the completing handshake); bresp_o 2'b00 in range, 2'b10 out of range with no storage change.
REQ-024 bresp_o/bvalid_o SHALL hold until bready_i; B handshake returns to WR_IDLE.
REQ-025 Read sample and write commit to the same word at the same edge SHALL return the old data (read-first).
REQ-026 wstrb_i = 0 in range SHALL complete with bresp 2'b00 and no storage change.

Reset
REQ-027 While rst_i is high at an edge SHALL force RD_IDLE, WR_IDLE, latency counter 0, rdata_o 0, rvalid_o 0, bvalid_o 0, bresp_o 0; after reset arready_o=awready_o=wready_o=1.
REQ-028 Reset mid-transaction SHALL abandon it without any storage write; storage contents are not reset.

Verification
REQ-029 AW+W same cycle, addr 0x8000_0010, data 0xA5A5_1234, strb 4'hF -> bvalid next cycle, bresp 00; read 0x8000_0010 -> rdata 0xA5A5_1234 RD_LATENCY cycles after AR.
REQ-030 Word holds 0x1122_3344; write strb 4'b0010 data 0x0000_FF00 -> read back 0x1122_FF44.
REQ-031 W presented 3 cycles before AW -> wready_o 0 after W accepted, awready_o 1; AW accept -> bvalid next cycle, correct data committed.
REQ-032 RD_LATENCY=3, rready_i held low 5 cycles after rvalid -> rvalid_o, rdata_o stable, arready_o 0 throughout; released -> arready_o 1 next cycle.
REQ-033 Write 0x0000_0000 -> bresp 2'b10, storage unchanged; read 0x0000_0000 -> rdata 0.
REQ-034 rst_i pulsed in RD_WAIT and in WR_HAVE_AW -> next cycle rvalid_o 0, bvalid_o 0, all ready outputs 1; target word unchanged.
